// File: rtl/action_mode_arbiter.sv
// rtl/action_mode_arbiter.sv - mode-selected motor action mux with STOP dwell on mode change and stale-source watchdog
module action_mode_arbiter #(
  parameter int              N_CH        = 3,
  parameter int              AW          = 4,
  parameter int              MODE_W      = 2,
  parameter logic [AW-1:0]   STOP_CODE   = 4'b1111,
  parameter int              DWELL_CYC   = 1000,
  parameter int              TIMEOUT_CYC = 50000
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic [MODE_W-1:0]    mode_in,
  input  logic [N_CH*AW-1:0]   act_bus,
  input  logic [N_CH-1:0]      act_vld,
  output logic [AW-1:0]        action,
  output logic [MODE_W-1:0]    cur_mode,
  output logic                 switching,
  output logic                 timeout_flag
);

  localparam int DW = $clog2(DWELL_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DW-1:0] DWELL_RELOAD = DW'(DWELL_CYC - 1);
  localparam logic [TW-1:0] WD_LAST      = TW'(TIMEOUT_CYC - 1);

  typedef enum logic {ST_DWELL, ST_RUN} state_t;

  state_t              state;
  logic [MODE_W-1:0]   mode_s1;
  logic [MODE_W-1:0]   mode_s;
  logic [DW-1:0]       dwell_cnt;
  logic [TW-1:0]       wd_cnt;

  logic                change;
  logic                sel_ok;
  logic                sel_vld;
  logic [AW-1:0]       sel_act;

  assign change = (mode_s != cur_mode);

  // Modes with no matching channel leave sel_ok low and select STOP.
  always_comb begin
    sel_ok  = 1'b0;
    sel_vld = 1'b0;
    sel_act = STOP_CODE;
    for (int k = 0; k < N_CH; k++) begin
      if (cur_mode == MODE_W'(k)) begin
        sel_ok  = 1'b1;
        sel_vld = act_vld[k];
        sel_act = act_bus[k*AW +: AW];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1      <= '0;
      mode_s       <= '0;
      state        <= ST_DWELL;
      cur_mode     <= '0;
      action       <= STOP_CODE;
      switching    <= 1'b1;
      timeout_flag <= 1'b0;
      dwell_cnt    <= DWELL_RELOAD;
      wd_cnt       <= '0;
    end else begin
      mode_s1 <= mode_in;
      mode_s  <= mode_s1;
      case (state)
        ST_DWELL: begin
          action    <= STOP_CODE;
          switching <= 1'b1;
          if (change) begin
            cur_mode  <= mode_s;
            dwell_cnt <= DWELL_RELOAD;
          end else if (dwell_cnt == '0) begin
            state        <= ST_RUN;
            switching    <= 1'b0;
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
          end else begin
            dwell_cnt <= dwell_cnt - DW'(1);
          end
        end
        ST_RUN: begin
          if (change) begin
            cur_mode  <= mode_s;
            action    <= STOP_CODE;
            dwell_cnt <= DWELL_RELOAD;
            switching <= 1'b1;
            state     <= ST_DWELL;
          end else if (!sel_ok) begin
            action       <= STOP_CODE;
            timeout_flag <= 1'b0;
          end else if (sel_vld) begin
            action       <= sel_act;
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
          end else if (wd_cnt == WD_LAST) begin
            // Watchdog saturates here; only a fresh act_vld pulse clears it.
            action       <= STOP_CODE;
            timeout_flag <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + TW'(1);
            action <= timeout_flag ? STOP_CODE : sel_act;
          end
        end
        default: state <= ST_DWELL;
      endcase
    end
  end

endmodule

// File: tb/tb_action_mode_arbiter.sv
// tb/tb_action_mode_arbiter.sv - directed self-checking bench for action_mode_arbiter
module tb_action_mode_arbiter;

  logic        clk_in;
  logic        rst_n;
  logic [1:0]  mode_in;
  logic [11:0] act_bus;
  logic [2:0]  act_vld;
  logic [3:0]  action;
  logic [1:0]  cur_mode;
  logic        switching;
  logic        timeout_flag;

  int checks;
  int errors;

  action_mode_arbiter #(
    .N_CH(3), .AW(4), .MODE_W(2), .STOP_CODE(4'b1111),
    .DWELL_CYC(4), .TIMEOUT_CYC(8)
  ) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .mode_in(mode_in),
    .act_bus(act_bus),
    .act_vld(act_vld),
    .action(action),
    .cur_mode(cur_mode),
    .switching(switching),
    .timeout_flag(timeout_flag)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic set_ch(input int k, input logic [3:0] v);
    act_bus[k*4 +: 4] = v;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    mode_in = 2'd0;
    act_bus = 12'h000;
    act_vld = 3'b000;
    set_ch(0, 4'h5);
    tick(2);
    check("rst_action", action, 4'hF);
    check("rst_switching", switching, 1);
    check("rst_cur_mode", cur_mode, 0);
    check("rst_timeout", timeout_flag, 0);

    // 1: dwell after reset, then channel 0 passes through
    rst_n = 1'b1;
    tick(3);
    check("t1_dwell_sw", switching, 1);
    check("t1_dwell_act", action, 4'hF);
    tick(1);
    check("t1_run_sw", switching, 0);
    check("t1_run_first_act", action, 4'hF);
    tick(1);
    check("t1_ch0", action, 4'h5);

    // 2: switch to mode 1, 3-clk sync latency then 4-clk dwell
    mode_in = 2'd1;
    set_ch(1, 4'hA);
    tick(2);
    check("t2_pre_change", action, 4'h5);
    tick(1);
    check("t2_stop", action, 4'hF);
    check("t2_sw", switching, 1);
    check("t2_mode", cur_mode, 1);
    tick(3);
    check("t2_dwell_end_sw", switching, 1);
    tick(1);
    check("t2_run_sw", switching, 0);
    tick(1);
    check("t2_chA", action, 4'hA);
    check("t2_mode_run", cur_mode, 1);

    // 3: back to mode 0, then watchdog timeout and resume
    mode_in = 2'd0;
    tick(7);
    check("t3_run", switching, 0);
    check("t3_mode", cur_mode, 0);
    tick(7);
    check("t3_pre_timeout_act", action, 4'h5);
    check("t3_pre_timeout_flag", timeout_flag, 0);
    tick(1);
    check("t3_timeout_act", action, 4'hF);
    check("t3_timeout_flag", timeout_flag, 1);
    tick(2);
    check("t3_stale_hold", action, 4'hF);
    act_vld = 3'b010;
    tick(1);
    act_vld = 3'b000;
    check("t3_other_vld_ignored", action, 4'hF);
    check("t3_other_vld_flag", timeout_flag, 1);
    set_ch(0, 4'h3);
    act_vld = 3'b001;
    tick(1);
    act_vld = 3'b000;
    check("t3_resume_act", action, 4'h3);
    check("t3_resume_flag", timeout_flag, 0);

    // 4: change during dwell restarts it
    mode_in = 2'd2;
    tick(3);
    check("t4_first_change_mode", cur_mode, 2);
    check("t4_first_change_sw", switching, 1);
    mode_in = 2'd0;
    tick(3);
    check("t4_second_change_mode", cur_mode, 0);
    check("t4_second_change_act", action, 4'hF);
    tick(3);
    check("t4_still_dwell", switching, 1);
    check("t4_still_stop", action, 4'hF);
    tick(1);
    check("t4_run_sw", switching, 0);
    tick(1);
    check("t4_ch0", action, 4'h3);

    // 5: out-of-range mode forces STOP with idle watchdog
    mode_in = 2'd3;
    tick(7);
    check("t5_run_sw", switching, 0);
    check("t5_mode", cur_mode, 3);
    check("t5_act", action, 4'hF);
    act_vld = 3'b111;
    tick(1);
    act_vld = 3'b000;
    check("t5_vld_ignored", action, 4'hF);
    tick(12);
    check("t5_long_act", action, 4'hF);
    check("t5_long_flag", timeout_flag, 0);

    // 6: asynchronous reset mid-run
    mode_in = 2'd0;
    set_ch(0, 4'h6);
    tick(8);
    check("t6_run_act", action, 4'h6);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_act", action, 4'hF);
    check("t6_async_sw", switching, 1);
    @(negedge clk_in);
    rst_n = 1'b1;
    tick(3);
    check("t6_dwell_sw", switching, 1);
    tick(1);
    check("t6_run_sw", switching, 0);
    check("t6_run_first", action, 4'hF);
    tick(1);
    check("t6_ch0", action, 4'h6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
